// File: rtl/period_detect.sv
// period_detect: measures the period of asynchronous clk_in in clk cycles and flags lock and loss of clk_in.
// Optional macro PERIOD_AVG_EN: report the truncated mean of the last four measurements instead of the raw one.
module period_detect #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned TOL        = 1,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwrdwn,
    input  logic             clk_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             lock,
    output logic             no_clk
);

    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_LAST = CNT_MAX - WIDTH'(1);
    localparam logic [WIDTH:0]   TOL_W    = (WIDTH+1)'(TOL);
    localparam logic [7:0]       LOCK_THR = 8'(LOCK_COUNT);

    typedef enum logic [1:0] {
        WAIT_EDGE,
        FIRST,
        TRACK,
        LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             lock_q, lock_d;
    logic             no_clk_q, no_clk_d;
    logic [7:0]       stable_q, stable_d;

    logic             rise;
    logic             cnt_last;
    logic             in_tol;
    logic             win_full;
    logic             preload;
    logic             shift;
    logic [7:0]       stable_inc;
    logic [WIDTH:0]   meas;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] meas_w;
    logic [WIDTH-1:0] track_period;

    always_comb begin
        s1_d = clk_in;
        s2_d = s1_q;
        s3_d = s2_q;
        if (pwrdwn) begin
            s1_d = 1'b0;
            s2_d = 1'b0;
            s3_d = 1'b0;
        end
    end

    assign rise = s2_q & ~s3_q;

    always_comb begin
        cnt_d = cnt_q;
        if (pwrdwn || rise) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Difference is one bit wider than the counter so |m-prev| never wraps.
    assign meas       = {1'b0, cnt_q} + (WIDTH+1)'(1);
    assign meas_w     = meas[WIDTH-1:0];
    assign diff       = (meas >= {1'b0, prev_q}) ? (meas - {1'b0, prev_q})
                                                 : ({1'b0, prev_q} - meas);
    assign in_tol     = (diff <= TOL_W);
    assign cnt_last   = (cnt_q >= CNT_LAST);
    assign stable_inc = (stable_q == 8'hFF) ? stable_q : (stable_q + 8'd1);

    always_comb begin
        state_d        = state_q;
        prev_d         = prev_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        lock_d         = lock_q;
        no_clk_d       = no_clk_q;
        stable_d       = stable_q;
        preload        = 1'b0;
        shift          = 1'b0;
        unique case (state_q)
            WAIT_EDGE: begin
                if (rise) begin
                    state_d  = FIRST;
                    no_clk_d = 1'b0;
                end
            end
            default: begin
                if (rise && cnt_last) begin
                    // Too long to be a valid period: drop it, but this edge opens a fresh measurement.
                    state_d  = FIRST;
                    lock_d   = 1'b0;
                    period_d = '0;
                    stable_d = '0;
                end else if (rise) begin
                    period_valid_d = 1'b1;
                    prev_d         = meas_w;
                    if (state_q == FIRST) begin
                        state_d  = TRACK;
                        stable_d = '0;
                        preload  = 1'b1;
                        period_d = meas_w;
                    end else if (in_tol) begin
                        stable_d = stable_inc;
                        shift    = 1'b1;
                        period_d = track_period;
                        if ((stable_inc >= LOCK_THR) && win_full) begin
                            state_d = LOCKED;
                            lock_d  = 1'b1;
                        end
                    end else begin
                        state_d  = TRACK;
                        lock_d   = 1'b0;
                        stable_d = '0;
                        preload  = 1'b1;
                        period_d = meas_w;
                    end
                end else if (cnt_last) begin
                    state_d  = WAIT_EDGE;
                    lock_d   = 1'b0;
                    no_clk_d = 1'b1;
                    period_d = '0;
                    stable_d = '0;
                end
            end
        endcase
        if (pwrdwn) begin
            state_d        = WAIT_EDGE;
            prev_d         = '0;
            period_d       = '0;
            period_valid_d = 1'b0;
            lock_d         = 1'b0;
            no_clk_d       = 1'b0;
            stable_d       = '0;
            preload        = 1'b0;
            shift          = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= WAIT_EDGE;
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            s3_q           <= 1'b0;
            cnt_q          <= '0;
            prev_q         <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            lock_q         <= 1'b0;
            no_clk_q       <= 1'b0;
            stable_q       <= '0;
        end else begin
            state_q        <= state_d;
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            s3_q           <= s3_d;
            cnt_q          <= cnt_d;
            prev_q         <= prev_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            lock_q         <= lock_d;
            no_clk_q       <= no_clk_d;
            stable_q       <= stable_d;
        end
    end

`ifdef PERIOD_AVG_EN
    logic [WIDTH-1:0] win_q [4];
    logic [WIDTH-1:0] win_d [4];
    logic [WIDTH+1:0] sum_q, sum_d;
    logic [WIDTH+1:0] sum_shift;
    logic [2:0]       win_cnt_q, win_cnt_d;

    assign sum_shift    = sum_q + {2'b00, meas_w} - {2'b00, win_q[3]};
    assign track_period = WIDTH'(sum_shift >> 2);
    // win_cnt counts shifts since preload; this shift makes it four.
    assign win_full     = (win_cnt_q >= 3'd3);

    always_comb begin
        win_d     = win_q;
        sum_d     = sum_q;
        win_cnt_d = win_cnt_q;
        if (pwrdwn) begin
            for (int unsigned i = 0; i < 4; i++) begin
                win_d[i] = '0;
            end
            sum_d     = '0;
            win_cnt_d = '0;
        end else if (preload) begin
            for (int unsigned i = 0; i < 4; i++) begin
                win_d[i] = meas_w;
            end
            sum_d     = {meas_w, 2'b00};
            win_cnt_d = '0;
        end else if (shift) begin
            win_d[0] = meas_w;
            for (int unsigned i = 1; i < 4; i++) begin
                win_d[i] = win_q[i-1];
            end
            sum_d = sum_shift;
            if (win_cnt_q != 3'd4) begin
                win_cnt_d = win_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                win_q[i] <= '0;
            end
            sum_q     <= '0;
            win_cnt_q <= '0;
        end else begin
            win_q     <= win_d;
            sum_q     <= sum_d;
            win_cnt_q <= win_cnt_d;
        end
    end
`else
    logic unused_avg;

    assign track_period = meas_w;
    assign win_full     = 1'b1;
    assign unused_avg   = preload ^ shift;
`endif

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign lock         = lock_q;
    assign no_clk       = no_clk_q;

endmodule

// File: tb/tb_period_detect.sv
// Directed bench for period_detect (WIDTH=8, TOL=1, LOCK_COUNT=4); clk_in changes only on clk negedges,
// so each rise is sampled by the first sync flop half a cycle later and period_valid follows on the 3rd posedge.
module tb_period_detect;

    localparam int W     = 8;
    localparam int CLK_P = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         pwrdwn;
    logic         clk_in;
    logic [W-1:0] period;
    logic         period_valid;
    logic         lock;
    logic         no_clk;

    int  n_tests = 0;
    int  n_fail  = 0;
    time last_rise;

    typedef struct {
        int n;
        int exp_raw;
        int exp_avg;
        bit exp_lock;
    } vec_t;

    vec_t vecs[$];

    period_detect #(
        .WIDTH(W),
        .TOL(1),
        .LOCK_COUNT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pwrdwn(pwrdwn),
        .clk_in(clk_in),
        .period(period),
        .period_valid(period_valid),
        .lock(lock),
        .no_clk(no_clk)
    );

    always #(CLK_P/2) clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_period(input int i);
`ifdef PERIOD_AVG_EN
        return vecs[i].exp_avg;
`else
        return vecs[i].exp_raw;
`endif
    endfunction

    task automatic add(input int n, input int raw, input int avg, input bit lk);
        vec_t v;
        v.n        = n;
        v.exp_raw  = raw;
        v.exp_avg  = avg;
        v.exp_lock = lk;
        vecs.push_back(v);
    endtask

    // Opening rise, then one full clk_in period per row; each row ends on a rise.
    task automatic gen(input int lo, input int hi);
        @(negedge clk);
        clk_in    = 1'b1;
        last_rise = $time;
        for (int i = lo; i <= hi; i++) begin
            repeat (vecs[i].n / 2) @(negedge clk);
            clk_in = 1'b0;
            repeat (vecs[i].n - vecs[i].n / 2) @(negedge clk);
            clk_in    = 1'b1;
            last_rise = $time;
        end
        repeat (4) @(negedge clk);
        clk_in = 1'b0;
    endtask

    task automatic chk(input int lo, input int hi);
        bit seen;
        int lat;
        @(posedge clk_in);
        repeat (3) @(posedge clk);
        #1;
        check("first_edge_no_pulse", int'(period_valid), 0);
        check("first_edge_no_clk", int'(no_clk), 0);
        for (int i = lo; i <= hi; i++) begin
            seen = 1'b0;
            for (int c = 0; c < vecs[i].n + 8 && !seen; c++) begin
                @(posedge clk);
                #1;
                seen = period_valid;
            end
            if (!seen) begin
                n_tests++;
                n_fail++;
                $display("FAIL pulse_timeout row %0d: period_valid=0, expected a pulse within %0d cycles", i, vecs[i].n + 8);
            end else begin
                lat = int'(($time - last_rise + 5) / CLK_P);
                check($sformatf("latency[%0d]", i), lat, 3);
                check($sformatf("period[%0d]", i), int'(period), exp_period(i));
                check($sformatf("lock[%0d]", i), int'(lock), int'(vecs[i].exp_lock));
                check($sformatf("no_clk[%0d]", i), int'(no_clk), 0);
                @(posedge clk);
                #1;
                check($sformatf("pulse_width[%0d]", i), int'(period_valid), 0);
            end
        end
    endtask

    initial begin
        #(CLK_P * 20000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int lat;
        rst    = 1'b1;
        pwrdwn = 1'b0;
        clk_in = 1'b0;

        // rows 0-13: lock at 10, tolerated 11, out-of-tolerance 12, relock at 12, drift 13/14
        for (int i = 0; i < 4; i++) add(10, 10, 10, 1'b0);
        add(10, 10, 10, 1'b1);
        add(11, 11, 10, 1'b1);
        add(10, 10, 10, 1'b1);
        add(12, 12, 12, 1'b0);
        for (int i = 0; i < 3; i++) add(12, 12, 12, 1'b0);
        add(12, 12, 12, 1'b1);
        add(13, 13, 12, 1'b1);
        add(14, 14, 12, 1'b1);
        // rows 14-18: restart at 20 after loss of clock
        for (int i = 0; i < 4; i++) add(20, 20, 20, 1'b0);
        add(20, 20, 20, 1'b1);
        // rows 19-23: fresh lock at 10 after power-down
        for (int i = 0; i < 4; i++) add(10, 10, 10, 1'b0);
        add(10, 10, 10, 1'b1);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clk_in = ~clk_in;
            @(posedge clk);
            #1;
            check("reset_outputs", int'({period, period_valid, lock, no_clk}), 0);
        end
        @(negedge clk);
        rst    = 1'b0;
        clk_in = 1'b0;
        repeat (3) @(negedge clk);

        fork
            gen(0, 13);
            chk(0, 13);
        join

        // clk_in stays low: the last rise opens a 255-cycle count ending in timeout
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(posedge clk);
            #1;
            seen = no_clk;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL no_clk_timeout: no_clk=0, expected 1 within 400 cycles");
        end else begin
            lat = int'(($time - last_rise + 5) / CLK_P);
            check("no_clk_latency", lat, 258);
            check("timeout_lock", int'(lock), 0);
            check("timeout_period", int'(period), 0);
            check("timeout_valid", int'(period_valid), 0);
        end

        fork
            gen(14, 18);
            chk(14, 18);
        join

        @(negedge clk);
        pwrdwn = 1'b1;
        @(posedge clk);
        #1;
        check("pwrdwn_outputs", int'({period, period_valid, lock, no_clk}), 0);
        @(negedge clk);
        @(negedge clk);
        pwrdwn = 1'b0;
        repeat (2) @(negedge clk);

        fork
            gen(19, 23);
            chk(19, 23);
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
